// File: rtl/pushbutton_alu.sv
// pushbutton_alu: four raw pushbuttons go through synchronisers, debouncers and
// rising-edge detectors. Each accepted press runs one registered ADD/SUB/AND/XOR
// on WIDTH-bit operands. Chain mode uses the previous result as operand A.
module pushbutton_alu #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             pushbutton_one,
   input  logic             pushbutton_two,
   input  logic             pushbutton_three,
   input  logic             pushbutton_four,
   input  logic             chain,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero,
   output logic [1:0]       last_op,
   output logic             done
);

   // The counter only needs to reach D-1: on the D-th differing edge the level
   // flips and the counter clears instead of storing D.
   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_AND = 2'b10,
      OP_XOR = 2'b11
   } op_t;

   logic [3:0]       btn_raw;
   logic [3:0]       sync_a;
   logic [3:0]       sync_b;
   logic [3:0]       deb_lvl;
   logic [3:0]       deb_dly;
   logic [3:0]       press;
   logic [CNT_W-1:0] deb_cnt [4];

   op_t              op_sel;
   op_t              last_op_q;
   logic             op_valid;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH:0]   sum_ext;
   logic [WIDTH:0]   diff_ext;
   logic [WIDTH-1:0] next_result;
   logic             next_carry;

   // Bit 0 is button one (highest priority), bit 3 is button four.
   assign btn_raw = {pushbutton_four, pushbutton_three, pushbutton_two, pushbutton_one};

   // Two-flop synchroniser for the asynchronous button inputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= btn_raw;
         sync_b <= sync_a;
      end
   end

   // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing edges.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         deb_lvl <= '0;
         for (int unsigned i = 0; i < 4; i++) deb_cnt[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (sync_b[i] != deb_lvl[i]) begin
               if (deb_cnt[i] == CNT_MAX) begin
                  deb_lvl[i] <= sync_b[i];
                  deb_cnt[i] <= '0;
               end else begin
                  deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
               end
            end else begin
               deb_cnt[i] <= '0;
            end
         end
      end
   end

   // Delayed debounced level for rising-edge detection.
   always_ff @(posedge clk) begin
      if (!reset_n) deb_dly <= '0;
      else          deb_dly <= deb_lvl;
   end

   assign press = deb_lvl & ~deb_dly;

   // Priority arbitration and next-result computation.
   always_comb begin
      op_valid    = |press;
      op_sel      = OP_XOR;
      if (press[0])      op_sel = OP_ADD;
      else if (press[1]) op_sel = OP_SUB;
      else if (press[2]) op_sel = OP_AND;
      op_a        = chain ? result : A;
      sum_ext     = {1'b0, op_a} + {1'b0, B};
      diff_ext    = {1'b0, op_a} - {1'b0, B};
      next_result = '0;
      next_carry  = 1'b0;
      case (op_sel)
         OP_ADD: begin
            next_result = sum_ext[WIDTH-1:0];
            next_carry  = sum_ext[WIDTH];
         end
         OP_SUB: begin
            next_result = diff_ext[WIDTH-1:0];
            next_carry  = diff_ext[WIDTH];
         end
         OP_AND: next_result = op_a & B;
         OP_XOR: next_result = op_a ^ B;
         default: next_result = '0;
      endcase
   end

   // Result/flag registers; reset overrides a coincident execute.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         result    <= '0;
         carry     <= 1'b0;
         zero      <= 1'b1;
         last_op_q <= OP_ADD;
         done      <= 1'b0;
      end else begin
         done <= op_valid;
         if (op_valid) begin
            result    <= next_result;
            carry     <= next_carry;
            zero      <= (next_result == '0);
            last_op_q <= op_sel;
         end
      end
   end

   assign last_op = last_op_q;

endmodule

// File: tb/tb_pushbutton_alu.sv
// Directed bench for pushbutton_alu with WIDTH=4, DEBOUNCE_CYCLES=4.
module tb_pushbutton_alu;

   localparam int W = 4;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [3:0]   btns;
   logic         chain;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic [W-1:0] result;
   logic         carry;
   logic         zero;
   logic [1:0]   last_op;
   logic         done;

   int n_cmp = 0;
   int n_mis = 0;
   int done_count = 0;
   int base;

   pushbutton_alu #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .pushbutton_one   (btns[0]),
      .pushbutton_two   (btns[1]),
      .pushbutton_three (btns[2]),
      .pushbutton_four  (btns[3]),
      .chain            (chain),
      .A                (A),
      .B                (B),
      .result           (result),
      .carry            (carry),
      .zero             (zero),
      .last_op          (last_op),
      .done             (done)
   );

   always #5 clk = ~clk;

   // done is a one-cycle pulse, so each negedge seeing it high is one event.
   always @(negedge clk) if (done === 1'b1) done_count++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Called #1 after an edge; the next edge is the first sample edge k.
   // Returns the number of edges after k at which done was first seen.
   task automatic measure(input string tag);
      int n;
      n = 0;
      @(posedge clk);
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            n = i;
            break;
         end
      end
      check({tag, "_latency"}, n, D + 2);
   endtask

   task automatic press(input logic [3:0] mask, input string tag);
      btns = mask;
      measure(tag);
   endtask

   task automatic release_all();
      btns = '0;
      repeat (2 * D + 6) @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [3:0] r, input logic c,
                            input logic z, input logic [1:0] op);
      check({tag, "_result"}, result, r);
      check({tag, "_carry"}, carry, c);
      check({tag, "_zero"}, zero, z);
      check({tag, "_last_op"}, last_op, op);
   endtask

   initial begin
      reset_n = 1'b0;
      btns    = '0;
      chain   = 1'b0;
      A       = '0;
      B       = '0;
      repeat (3) @(posedge clk);
      #1;
      check_out("reset", 4'b0000, 1'b0, 1'b1, 2'b00);
      check("reset_done", done, 1'b0);
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Basic add, then hold to confirm a single event and release silently.
      A = 4'b0011; B = 4'b0001; base = done_count;
      press(4'b0001, "add");
      check_out("add", 4'b0100, 1'b0, 1'b0, 2'b00);
      repeat (20) @(posedge clk);
      #1;
      check("add_hold_events", done_count - base, 1);
      release_all();
      check("add_release_events", done_count - base, 1);

      // Overflow wraps with carry set.
      A = 4'b1111; B = 4'b0001;
      press(4'b0001, "ovf");
      check_out("ovf", 4'b0000, 1'b1, 1'b1, 2'b00);
      release_all();

      // Borrow.
      A = 4'b0001; B = 4'b0011;
      press(4'b0010, "sub");
      check_out("sub", 4'b1110, 1'b1, 1'b0, 2'b01);
      release_all();

      A = 4'b1100; B = 4'b1010;
      press(4'b0100, "and");
      check_out("and", 4'b1000, 1'b0, 1'b0, 2'b10);
      release_all();

      A = 4'b1010; B = 4'b1010;
      press(4'b1000, "xor");
      check_out("xor", 4'b0000, 1'b0, 1'b1, 2'b11);
      release_all();

      // Bounce on press then on release.
      A = 4'b0101; B = 4'b0010; base = done_count;
      for (int i = 0; i < 5; i++) begin
         btns = 4'b0001;
         repeat (2) @(posedge clk);
         #1;
         btns = 4'b0000;
         repeat (2) @(posedge clk);
         #1;
      end
      check("bounce_early_events", done_count - base, 0);
      press(4'b0001, "bounce");
      check_out("bounce", 4'b0111, 1'b0, 1'b0, 2'b00);
      for (int i = 0; i < 5; i++) begin
         btns = 4'b0000;
         repeat (2) @(posedge clk);
         #1;
         btns = 4'b0001;
         repeat (2) @(posedge clk);
         #1;
      end
      release_all();
      check("bounce_events", done_count - base, 1);

      // Simultaneous two and four: SUB wins.
      A = 4'b0110; B = 4'b0011; base = done_count;
      press(4'b1010, "simul");
      check_out("simul", 4'b0011, 1'b0, 1'b0, 2'b01);
      release_all();
      check("simul_events", done_count - base, 1);

      // Chain: start at 0100, then accumulate B=1 three times; A is ignored.
      A = 4'b0011; B = 4'b0001;
      press(4'b0001, "chain_seed");
      check("chain_seed_result", result, 4'b0100);
      release_all();
      chain = 1'b1; A = 4'b1001; base = done_count;
      press(4'b0001, "chain1");
      check("chain1_result", result, 4'b0101);
      release_all();
      press(4'b0001, "chain2");
      check("chain2_result", result, 4'b0110);
      release_all();
      press(4'b0001, "chain3");
      check("chain3_result", result, 4'b0111);
      release_all();
      check("chain_events", done_count - base, 3);
      chain = 1'b0;

      // Reset mid-debounce, button held through reset release.
      A = 4'b0010; B = 4'b0010; base = done_count;
      btns = 4'b0001;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_out("rst_mid", 4'b0000, 1'b0, 1'b1, 2'b00);
      check("rst_mid_done", done, 1'b0);
      check("rst_mid_events", done_count - base, 0);
      reset_n = 1'b1;
      measure("rst_rel");
      check_out("rst_rel", 4'b0100, 1'b0, 1'b0, 2'b00);
      release_all();
      check("rst_rel_events", done_count - base, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/pushbutton_alu.md
# pushbutton_alu

Clocked, parametrised successor to the four-pushbutton lab-practical ALU. Four raw pushbuttons are synchronised, debounced and edge-detected. Each debounced press triggers exactly one registered arithmetic/logic operation on WIDTH-bit operands. An optional chain mode feeds the previous result back as operand A. The block sits between the board switches/buttons and the LED/7-segment display logic.

## Interface
- WIDTH, 4: operand and result width in bits, at least 1.
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required to accept a button level change, at least 1.
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  reset, synchronous, active-low.
- pushbutton_one  input  1  raw, asynchronous; selects ADD.
- pushbutton_two  input  1  raw, asynchronous; selects SUB.
- pushbutton_three  input  1  raw, asynchronous; selects AND.
- pushbutton_four  input  1  raw, asynchronous; selects XOR.
- chain  input  1  when 1, operand A is the current `result` instead of port A; sampled in the press-pulse cycle.
- A  input  WIDTH  operand A, unsigned; sampled in the press-pulse cycle.
- B  input  WIDTH  operand B, unsigned; sampled in the press-pulse cycle.
- result  output  WIDTH  registered result.
- carry  output  1  ADD: carry-out. SUB: borrow, meaning A < B unsigned. AND/XOR: 0.
- zero  output  1  1 when the newly registered result is all zeros.
- last_op  output  2  code of the last executed operation: 00 ADD, 01 SUB, 10 AND, 11 XOR.
- done  output  1  single-cycle pulse, high in the cycle after result/flags update.

## Operation
- Per-button pipeline:
  - Two-flop synchroniser; both flops reset to 0.
  - Debouncer holds a debounced level (reset 0) and a counter sized for DEBOUNCE_CYCLES (reset 0).
  - On each edge where the synchronised level differs from the debounced level, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - Any edge where the synchronised level equals the debounced level clears the counter, so a glitch restarts the count.
  - Edge detector: press pulse = debounced level AND NOT its one-cycle-delayed copy. The delayed copy resets to 0.
  - Button release, meaning a debounced 1→0 transition, produces no event.
- Arbitration:
  - Pulses on several buttons in the same cycle resolve by fixed priority: one > two > three > four.
  - Exactly one operation executes; lower-priority pulses that cycle are dropped.
- Execute, on the edge closing the press-pulse cycle:
  - opA = chain ? result : A.
  - ADD: {carry, result} = opA + B, computed at WIDTH+1 bits.
  - SUB: result = (opA − B) mod 2^WIDTH; carry = (opA < B).
  - AND: result = opA & B; carry = 0.
  - XOR: result = opA ^ B; carry = 0.
  - zero is computed from the new result. last_op takes the executed op code.
- Between events, result, carry, zero and last_op hold their values.
- Reset values: result 0, carry 0, zero 1, last_op 00, done 0. All synchroniser, debouncer and edge state is also cleared.

## Timing
- Stimulus: button high, first sampled at edge k, held stable.
  - Debounced level rises at edge k+1+D, where D = DEBOUNCE_CYCLES.
  - Press pulse is high during the cycle after edge k+1+D.
  - result, flags and last_op update at edge k+2+D.
  - done is high during the cycle after edge k+2+D.
- A button held indefinitely gives exactly one event. The next event requires a debounced release followed by a new debounced press.
- Minimum press-to-press spacing: 2·D+2 cycles of stable levels.
- reset_n low at any edge:
  - Discards any in-progress debounce and any pending pulse.
  - Forces all outputs to their reset values at that edge, overriding a simultaneous execute.
- Button held through reset release: treated as a fresh press; result updates D+2 edges after the first edge with reset_n high.
- Wrap-around: ADD overflow and SUB underflow wrap modulo 2^WIDTH, signalled only by carry.

## Test plan
- Basic add (WIDTH=4, D=4, chain=0): A=0011, B=0001, press button one → result 0100, carry 0, zero 0, last_op 00, done one pulse exactly 6 edges after first sample.
- Overflow and borrow: ADD A=1111, B=0001 → result 0000, carry 1, zero 1. SUB A=0001, B=0011 → result 1110, carry 1, last_op 01.
- Bounce rejection: button one toggles every 2 cycles for 20 cycles, then stays high → exactly one done pulse, D+2 edges after the stable level begins. No done pulse on release bounce.
- Simultaneous press: buttons two and four pressed on the same edge, A=0110, B=0011 → single SUB result 0011, last_op 01, one done pulse.
- Chain mode: chain=1, result=0100, B=0001, three presses of button one → results 0101, 0110, 0111, one done pulse per press.
- Reset mid-debounce: assert reset_n low 2 cycles after a press starts → no done pulse, outputs at reset values. With the button held after release → result updates D+2 edges after release.
